// File: rtl/rast_tri_queue_pkg.sv
// Shared rast parameters, payload types and helpers for the triangle input queue.
package rast_params;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;
    localparam int unsigned QDEPTH = 4;

    typedef logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]                 color_t;

    // Source of the next head-register contents.
    typedef enum logic [1:0] {
        HEAD_HOLD,
        HEAD_MEM,
        HEAD_IN,
        HEAD_CLR
    } head_sel_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rast_tri_queue_mem.sv
// Register-file storage for the triangle queue: one write port, one asynchronous read port.
module rast_tri_queue_mem #(
    parameter int unsigned W     = 288,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rast_tri_queue.sv
// DEPTH-entry first-word-fall-through triangle queue feeding rast R10 inputs.
// Optional statistics counters enabled by macro RAST_TRI_QUEUE_STATS_EN.
module rast_tri_queue #(
    parameter int unsigned SIGFIG = rast_params::SIGFIG,
    parameter int unsigned VERTS  = rast_params::VERTS,
    parameter int unsigned AXIS   = rast_params::AXIS,
    parameter int unsigned COLORS = rast_params::COLORS,
    parameter int unsigned DEPTH  = rast_params::QDEPTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  in_tri_S,
    input  logic [COLORS-1:0][SIGFIG-1:0]                  in_color_U,
    input  logic                                           in_valid_H,
    output logic                                           in_ready_H,
    input  logic                                           flush_H,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R10S,
    output logic [COLORS-1:0][SIGFIG-1:0]                  color_R10U,
    output logic                                           validTri_R10H,
    input  logic                                           halt_RnnnnL,
    output logic [$clog2(DEPTH+1)-1:0]                     count_U
`ifdef RAST_TRI_QUEUE_STATS_EN
    ,
    output logic [31:0]                                    stat_push_U,
    output logic [31:0]                                    stat_pop_U,
    output logic [31:0]                                    stat_stall_U
`endif
);

    import rast_params::*;

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = SIGFIG*VERTS*AXIS;
    localparam int unsigned KW = SIGFIG*COLORS;
    localparam int unsigned W  = TW + KW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [W-1:0]  rd_word;
    logic          live, push, pop;
    head_sel_e     head_sel;

    // live keeps ready low while reset is asserted even though count is 0.
    assign in_ready_H = live && (count_U < FULL) && !flush_H;
    assign push       = in_valid_H && in_ready_H;
    assign pop        = validTri_R10H && halt_RnnnnL;
    assign rd_next    = rd_ptr + AW'(1);

    rast_tri_queue_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_tri_S, in_color_U}),
        .raddr (rd_next),
        .rdata (rd_word)
    );

    // Storage holds every entry including the head; the head register mirrors
    // mem[rd_ptr], so on a pop the successor is either already stored or is
    // the triangle being pushed on the same edge.
    always_comb begin
        head_sel = HEAD_HOLD;
        if (pop) begin
            if (count_U > CW'(1))
                head_sel = HEAD_MEM;
            else if (push)
                head_sel = HEAD_IN;
            else
                head_sel = HEAD_CLR;
        end else if (!validTri_R10H && push) begin
            head_sel = HEAD_IN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live          <= 1'b0;
            count_U       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            validTri_R10H <= 1'b0;
            tri_R10S      <= '0;
            color_R10U    <= '0;
        end else begin
            live <= 1'b1;
            if (flush_H) begin
                count_U       <= '0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                validTri_R10H <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_next;
                case ({push, pop})
                    2'b10:   count_U <= count_U + CW'(1);
                    2'b01:   count_U <= count_U - CW'(1);
                    default: ;
                endcase
                case (head_sel)
                    HEAD_MEM: begin
                        tri_R10S      <= rd_word[W-1:KW];
                        color_R10U    <= rd_word[KW-1:0];
                        validTri_R10H <= 1'b1;
                    end
                    HEAD_IN: begin
                        tri_R10S      <= in_tri_S;
                        color_R10U    <= in_color_U;
                        validTri_R10H <= 1'b1;
                    end
                    HEAD_CLR: validTri_R10H <= 1'b0;
                    default:  ;
                endcase
            end
        end
    end

`ifdef RAST_TRI_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_push_U  <= '0;
            stat_pop_U   <= '0;
            stat_stall_U <= '0;
        end else if (flush_H) begin
            stat_push_U  <= '0;
            stat_pop_U   <= '0;
            stat_stall_U <= '0;
        end else begin
            if (push) stat_push_U <= sat_inc(stat_push_U);
            if (pop)  stat_pop_U  <= sat_inc(stat_pop_U);
            if (validTri_R10H && !halt_RnnnnL) stat_stall_U <= sat_inc(stat_stall_U);
        end
    end
`endif

endmodule

// File: tb/tb_rast_tri_queue.sv
// Directed scoreboard bench for rast_tri_queue; honours RAST_TRI_QUEUE_STATS_EN when defined.
module tb_rast_tri_queue;

    import rast_params::*;

    localparam int unsigned DEPTH = QDEPTH;
    localparam int unsigned W = SIGFIG*VERTS*AXIS + SIGFIG*COLORS;

    logic                  clk = 1'b0;
    logic                  rst;
    tri_t                  in_tri_S;
    color_t                in_color_U;
    logic                  in_valid_H;
    logic                  in_ready_H;
    logic                  flush_H;
    tri_t                  tri_R10S;
    color_t                color_R10U;
    logic                  validTri_R10H;
    logic                  halt_RnnnnL;
    logic [2:0]            count_U;
`ifdef RAST_TRI_QUEUE_STATS_EN
    logic [31:0]           stat_push_U, stat_pop_U, stat_stall_U;
`endif

    rast_tri_queue #(
        .SIGFIG (SIGFIG),
        .VERTS  (VERTS),
        .AXIS   (AXIS),
        .COLORS (COLORS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_tri_S      (in_tri_S),
        .in_color_U    (in_color_U),
        .in_valid_H    (in_valid_H),
        .in_ready_H    (in_ready_H),
        .flush_H       (flush_H),
        .tri_R10S      (tri_R10S),
        .color_R10U    (color_R10U),
        .validTri_R10H (validTri_R10H),
        .halt_RnnnnL   (halt_RnnnnL),
        .count_U       (count_U)
`ifdef RAST_TRI_QUEUE_STATS_EN
        ,
        .stat_push_U   (stat_push_U),
        .stat_pop_U    (stat_pop_U),
        .stat_stall_U  (stat_stall_U)
`endif
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned issued = 0;
    logic [W-1:0] sb[$];
    logic [31:0] m_push = 0, m_pop = 0, m_stall = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef RAST_TRI_QUEUE_STATS_EN
        check({tag, "_stat_push"},  W'(stat_push_U),  W'(m_push));
        check({tag, "_stat_pop"},   W'(stat_pop_U),   W'(m_pop));
        check({tag, "_stat_stall"}, W'(stat_stall_U), W'(m_stall));
`endif
    endtask

    function automatic tri_t rnd_tri();
        tri_t t;
        for (int unsigned v = 0; v < VERTS; v++)
            for (int unsigned a = 0; a < AXIS; a++)
                t[v][a] = SIGFIG'($urandom);
        return t;
    endfunction

    function automatic color_t rnd_color();
        color_t c;
        for (int unsigned k = 0; k < COLORS; k++)
            c[k] = SIGFIG'($urandom);
        return c;
    endfunction

    // One clock cycle: drive inputs, check pre-edge state against the model,
    // advance across the edge, then check hold stability and update the model.
    task automatic step(input logic v, input tri_t t, input color_t c, input logic h,
                        input logic f, output logic acc);
        logic exp_ready, will_push, will_pop, hold;
        logic [W:0] snap;
        in_valid_H  = v;
        in_tri_S    = t;
        in_color_U  = c;
        halt_RnnnnL = h;
        flush_H     = f;
        #1;
        exp_ready = (sb.size() < DEPTH) && !f;
        check("ready", W'(in_ready_H), W'(exp_ready));
        check("count", W'(count_U), W'(sb.size()));
        check("valid", W'(validTri_R10H), W'(sb.size() != 0));
        if (sb.size() != 0)
            check("head", {tri_R10S, color_R10U}, sb[0]);
        check_stats("pre");
        will_push = v && exp_ready;
        will_pop  = (sb.size() != 0) && h && !f;
        hold      = (sb.size() != 0) && !h && !f;
        snap      = {tri_R10S, color_R10U, validTri_R10H};
        @(posedge clk);
        #1;
        if (hold)
            check("hold", W'(snap != {tri_R10S, color_R10U, validTri_R10H}), W'(0));
        if (f) begin
            sb.delete();
            m_push = 0; m_pop = 0; m_stall = 0;
        end else begin
            if ((sb.size() != 0) && !h) m_stall = m_stall + 1;
            if (will_pop) begin
                void'(sb.pop_front());
                issued++;
                m_pop = m_pop + 1;
            end
            if (will_push) begin
                sb.push_back({t, c});
                m_push = m_push + 1;
            end
        end
        acc = will_push;
    endtask

    initial begin
        tri_t   t0, cur_t;
        color_t c0, cur_c;
        logic   acc;
        int unsigned idx, base;

        rst = 1'b0; in_valid_H = 1'b0; flush_H = 1'b0; halt_RnnnnL = 1'b1;
        in_tri_S = '0; in_color_U = '0;
        #3;
        check("rst_count", W'(count_U), W'(0));
        check("rst_valid", W'(validTri_R10H), W'(0));
        check("rst_ready", W'(in_ready_H), W'(0));
        check("rst_data", {tri_R10S, color_R10U}, '0);
        check_stats("rst");
        #9 rst = 1'b1;
        @(posedge clk);
        #1;

        // Single triangle, exact payload, count 0->1->0
        t0 = '0;
        t0[0][2] = 24'd1;
        t0[1][0] = 24'd16; t0[1][2] = 24'd1;
        t0[2][1] = 24'd16; t0[2][2] = 24'd1;
        c0 = '0;
        c0[0] = 24'd255;
        step(1'b1, t0, c0, 1'b1, 1'b0, acc);
        check("single_acc", W'(acc), W'(1));
        check("single_payload", {tri_R10S, color_R10U}, {t0, c0});
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Fill while halted, fifth accepted only after first pop
        for (int unsigned i = 0; i < 4; i++)
            step(1'b1, rnd_tri(), rnd_color(), 1'b0, 1'b0, acc);
        cur_t = rnd_tri(); cur_c = rnd_color();
        step(1'b1, cur_t, cur_c, 1'b0, 1'b0, acc);
        check("full_reject", W'(acc), W'(0));
        step(1'b1, cur_t, cur_c, 1'b1, 1'b0, acc);
        check("full_pop_noacc", W'(acc), W'(0));
        step(1'b1, cur_t, cur_c, 1'b0, 1'b0, acc);
        check("fifth_acc", W'(acc), W'(1));
        for (int unsigned i = 0; i < 8 && sb.size() != 0; i++)
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("fill_drained", W'(count_U), W'(0));

        // Continuous stream at full throughput
        base = issued;
        for (int unsigned i = 0; i < 16; i++)
            step(1'b1, rnd_tri(), rnd_color(), 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("stream_issues", W'(issued - base), W'(16));

        // Random backpressure, 100 triangles
        base = issued; idx = 0;
        cur_t = rnd_tri(); cur_c = rnd_color();
        for (int unsigned cyc = 0; cyc < 2000 && idx < 100; cyc++) begin
            step(1'b1, cur_t, cur_c, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                idx++;
                cur_t = rnd_tri(); cur_c = rnd_color();
            end
        end
        check("rnd_accepted", W'(idx), W'(100));
        for (int unsigned i = 0; i < 20 && sb.size() != 0; i++)
            step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        check("rnd_issued", W'(issued - base), W'(100));

        // Flush with three entries and an offered triangle
        for (int unsigned i = 0; i < 3; i++)
            step(1'b1, rnd_tri(), rnd_color(), 1'b0, 1'b0, acc);
        step(1'b1, rnd_tri(), rnd_color(), 1'b0, 1'b1, acc);
        check("flush_noacc", W'(acc), W'(0));
        check("flush_count", W'(count_U), W'(0));
        check("flush_valid", W'(validTri_R10H), W'(0));
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b1, t0, c0, 1'b0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Asynchronous reset between edges mid-stream
        for (int unsigned i = 0; i < 3; i++)
            step(1'b1, rnd_tri(), rnd_color(), 1'b0, 1'b0, acc);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", W'(validTri_R10H), W'(0));
        check("arst_count", W'(count_U), W'(0));
        check("arst_ready", W'(in_ready_H), W'(0));
        sb.delete();
        m_push = 0; m_pop = 0; m_stall = 0;
        check_stats("arst");
        in_valid_H = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, t0, c0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
